// File: rtl/fifo_wr_ctrl_pkg.sv
// Shared async-FIFO definitions: geometry and Gray/binary pointer conversions
// used by both the write and read controllers.
package fifo_wr_ctrl_pkg;

  localparam int unsigned FIFO_ADDR_WIDTH = 3;
  localparam int unsigned FIFO_DEPTH      = 1 << FIFO_ADDR_WIDTH;

  typedef logic [31:0] ptr_word_t;

  function automatic ptr_word_t bin2gray(input ptr_word_t b);
    return b ^ (b >> 1);
  endfunction

  // Prefix-XOR from the MSB down, done in log2 steps instead of a bit loop.
  function automatic ptr_word_t gray2bin(input ptr_word_t g);
    ptr_word_t b;
    b = g;
    b = b ^ (b >> 1);
    b = b ^ (b >> 2);
    b = b ^ (b >> 4);
    b = b ^ (b >> 8);
    b = b ^ (b >> 16);
    return b;
  endfunction

endpackage

// File: rtl/fifo_wr_ctrl_ptr_sync.sv
// N-stage, width-parameterised pointer synchroniser with asynchronous
// active-low reset; shared by the write and read controllers.
module ptr_sync #(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] sync_q [STAGES];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q[0] <= d_i;
      for (int unsigned i = 1; i < STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/fifo_wr_ctrl.sv
// Async FIFO write-side controller (W_CLK domain): write pointer, full flag,
// overflow pulse. Define FIFO_WR_ALMOST_FULL_EN to add w_level/w_almost_full.
module fifo_wr_ctrl
  import fifo_wr_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = FIFO_ADDR_WIDTH,
  parameter int unsigned SYNC_STAGES  = 2,
  parameter int unsigned AF_THRESHOLD = 6
) (
  input  logic                  W_CLK,
  input  logic                  W_RST,
  input  logic                  W_INC,
  input  logic [ADDR_WIDTH:0]   rptr_gray,
  output logic [ADDR_WIDTH-1:0] waddr,
  output logic                  w_en,
  output logic                  W_FULL,
  output logic [ADDR_WIDTH:0]   wptr_gray,
  output logic                  w_overflow
`ifdef FIFO_WR_ALMOST_FULL_EN
  ,
  output logic [ADDR_WIDTH:0]   w_level,
  output logic                  w_almost_full
`endif
);

  localparam int unsigned PW = ADDR_WIDTH + 1;

  logic [PW-1:0] wbin_q, wbin_d;
  logic [PW-1:0] wgray_q, wgray_d;
  logic [PW-1:0] rq_sync;
  logic [PW-1:0] full_cmp;
  logic          full_q, full_d;
  logic          ovf_q, ovf_d;
  logic          inc;

  ptr_sync #(
    .WIDTH  (PW),
    .STAGES (SYNC_STAGES)
  ) u_rptr_sync (
    .clk_i  (W_CLK),
    .rst_ni (W_RST),
    .d_i    (rptr_gray),
    .q_o    (rq_sync)
  );

  // Full compares against the synchronised read pointer with its top two
  // Gray bits inverted: write pointer exactly one depth ahead.
  always_comb begin
    inc      = W_INC && !full_q;
    wbin_d   = wbin_q + {{ADDR_WIDTH{1'b0}}, inc};
    wgray_d  = PW'(bin2gray(ptr_word_t'(wbin_d)));
    full_cmp = {~rq_sync[PW-1:PW-2], rq_sync[PW-3:0]};
    full_d   = (wgray_d == full_cmp);
    ovf_d    = W_INC && full_q;
  end

  always_ff @(posedge W_CLK or negedge W_RST) begin
    if (!W_RST) begin
      wbin_q  <= '0;
      wgray_q <= '0;
      full_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      wbin_q  <= wbin_d;
      wgray_q <= wgray_d;
      full_q  <= full_d;
      ovf_q   <= ovf_d;
    end
  end

  assign waddr      = wbin_q[ADDR_WIDTH-1:0];
  assign w_en       = inc && W_RST;
  assign W_FULL     = full_q;
  assign wptr_gray  = wgray_q;
  assign w_overflow = ovf_q;

`ifdef FIFO_WR_ALMOST_FULL_EN
  logic [PW-1:0] rq_bin;
  logic [PW-1:0] level_d, level_q;
  logic          af_d, af_q;

  always_comb begin
    rq_bin  = PW'(gray2bin(ptr_word_t'(rq_sync)));
    level_d = wbin_d - rq_bin;
    af_d    = (level_d >= PW'(AF_THRESHOLD));
  end

  always_ff @(posedge W_CLK or negedge W_RST) begin
    if (!W_RST) begin
      level_q <= '0;
      af_q    <= 1'b0;
    end else begin
      level_q <= level_d;
      af_q    <= af_d;
    end
  end

  assign w_level       = level_q;
  assign w_almost_full = af_q;
`endif

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// Scoreboard bench for fifo_wr_ctrl: occupancy-count reference model, directed
// phases followed by randomized writes and read-pointer advances.
module tb_fifo_wr_ctrl;

  localparam int AW  = 3;
  localparam int SS  = 2;
  localparam int AF  = 6;
  localparam int MOD = 16;
  localparam int DEP = 8;

  logic       W_CLK = 1'b0;
  logic       W_RST;
  logic       W_INC;
  logic [3:0] rptr_gray;
  logic [2:0] waddr;
  logic       w_en;
  logic       W_FULL;
  logic [3:0] wptr_gray;
  logic       w_overflow;
`ifdef FIFO_WR_ALMOST_FULL_EN
  logic [3:0] w_level;
  logic       w_almost_full;
`endif

  fifo_wr_ctrl #(
    .ADDR_WIDTH   (AW),
    .SYNC_STAGES  (SS),
    .AF_THRESHOLD (AF)
  ) dut (
    .W_CLK      (W_CLK),
    .W_RST      (W_RST),
    .W_INC      (W_INC),
    .rptr_gray  (rptr_gray),
    .waddr      (waddr),
    .w_en       (w_en),
    .W_FULL     (W_FULL),
    .wptr_gray  (wptr_gray),
    .w_overflow (w_overflow)
`ifdef FIFO_WR_ALMOST_FULL_EN
    ,
    .w_level       (w_level),
    .w_almost_full (w_almost_full)
`endif
  );

  always #5 W_CLK = ~W_CLK;

  typedef struct {
    int waddr;
    int gray;
    bit full;
    bit ovf;
    bit wen;
    int level;
    bit af;
  } exp_t;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;

  // Reference model: write count mod 16, read count as seen SS edges late.
  int wcnt;
  int rbin;
  bit m_full;
  bit m_ovf;
  int m_level;
  bit m_af;
  int hist[$];

  function automatic int gray_of(input int b);
    return (b ^ (b >> 1)) & (MOD - 1);
  endfunction

  function automatic void model_reset();
    wcnt    = 0;
    rbin    = 0;
    m_full  = 1'b0;
    m_ovf   = 1'b0;
    m_level = 0;
    m_af    = 1'b0;
    hist.delete();
  endfunction

  function automatic void model_edge(input bit inc, input int r);
    int rs;
    int occ;
    rs     = (hist.size() >= SS) ? hist[hist.size() - SS] : 0;
    m_ovf  = inc && m_full;
    if (inc && !m_full) wcnt = (wcnt + 1) % MOD;
    occ     = (wcnt - rs + MOD) % MOD;
    m_full  = (occ == DEP);
    m_level = occ;
    m_af    = (occ >= AF);
    hist.push_back(r);
    if (hist.size() > SS) void'(hist.pop_front());
  endfunction

  task automatic push_exp(input bit wen);
    exp_t e;
    e.waddr = wcnt % DEP;
    e.gray  = gray_of(wcnt);
    e.full  = m_full;
    e.ovf   = m_ovf;
    e.wen   = wen;
    e.level = m_level;
    e.af    = m_af;
    sb.push_back(e);
  endtask

  // Entered at posedge+1; returns at the following posedge+1.
  task automatic step(input bit inc, input int r);
    W_INC     = inc;
    rbin      = r;
    rptr_gray = 4'(gray_of(r));
    push_exp(inc && !m_full);
    @(posedge W_CLK);
    model_edge(inc, r);
    #1;
  endtask

  // Asserts reset mid-cycle with a write request pending; outputs must clear
  // before the next clock edge.
  task automatic pulse_reset();
    #2;
    W_RST     = 1'b0;
    W_INC     = 1'b1;
    rptr_gray = '0;
    model_reset();
    push_exp(1'b0);
    @(negedge W_CLK);
    #2;
    W_INC = 1'b0;
    W_RST = 1'b1;
    @(posedge W_CLK);
    model_edge(1'b0, 0);
    #1;
  endtask

  always @(negedge W_CLK) begin
    if (sb.size() != 0) begin
      exp_t e;
      bit   bad;
      e   = sb.pop_front();
      bad = 1'b0;
      vectors++;
      if (int'(waddr) != e.waddr) begin
        $display("FAIL waddr @%0t: got %0d expected %0d", $time, waddr, e.waddr);
        bad = 1'b1;
      end
      if (int'(wptr_gray) != e.gray) begin
        $display("FAIL wptr_gray @%0t: got %b expected %b", $time, wptr_gray, 4'(e.gray));
        bad = 1'b1;
      end
      if (W_FULL !== e.full) begin
        $display("FAIL W_FULL @%0t: got %b expected %b", $time, W_FULL, e.full);
        bad = 1'b1;
      end
      if (w_overflow !== e.ovf) begin
        $display("FAIL w_overflow @%0t: got %b expected %b", $time, w_overflow, e.ovf);
        bad = 1'b1;
      end
      if (w_en !== e.wen) begin
        $display("FAIL w_en @%0t: got %b expected %b", $time, w_en, e.wen);
        bad = 1'b1;
      end
`ifdef FIFO_WR_ALMOST_FULL_EN
      if (int'(w_level) != e.level) begin
        $display("FAIL w_level @%0t: got %0d expected %0d", $time, w_level, e.level);
        bad = 1'b1;
      end
      if (w_almost_full !== e.af) begin
        $display("FAIL w_almost_full @%0t: got %b expected %b", $time, w_almost_full, e.af);
        bad = 1'b1;
      end
`endif
      if (bad) miscompares++;
    end
  end

  initial begin
    W_RST     = 1'b0;
    W_INC     = 1'b0;
    rptr_gray = '0;
    model_reset();
    #6;
    pulse_reset();

    // Burst to full, then keep writing while full.
    for (int i = 0; i < 8; i++) step(1'b1, 0);
    for (int i = 0; i < 3; i++) step(1'b1, 0);

    // One read frees a slot after the synchroniser delay, then refill.
    for (int i = 0; i < 4; i++) step(1'b0, 1);
    step(1'b1, 1);
    step(1'b1, 1);
    step(1'b0, 1);

    // Async reset mid-cycle at waddr=5, not full.
    pulse_reset();
    for (int i = 0; i < 5; i++) step(1'b1, 0);
    pulse_reset();

    // Almost-full level: 6 writes against an idle reader.
    for (int i = 0; i < 6; i++) step(1'b1, 0);
    step(1'b0, 0);
    pulse_reset();

    // Wrap-around with the reader trailing two entries behind.
    step(1'b1, 0);
    step(1'b1, 0);
    for (int i = 0; i < 20; i++) step(1'b1, (wcnt + MOD - 2) % MOD);
    pulse_reset();

    // Randomized traffic; reader never passes the committed write count.
    for (int i = 0; i < 500; i++) begin
      int  r;
      bit  inc;
      r   = rbin;
      if (r != wcnt && $urandom_range(0, 2) == 0) r = (r + 1) % MOD;
      inc = ($urandom_range(0, 3) != 0);
      step(inc, r);
      if ($urandom_range(0, 199) == 0) pulse_reset();
    end

    #6;
    if (sb.size() != 0) begin
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
      miscompares++;
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
